// File: rtl/bike_controller.sv
// rtl/bike_controller.sv - light-bike position/heading sequencer feeding the pixel-collision detector
// Optional build macro BIKE_WRAP_EN: out-of-bounds steps wrap to the opposite edge instead of crashing.
module bike_controller #(
    parameter int START_X      = 320,
    parameter int START_Y      = 240,
    parameter int START_ORIENT = 3,
    parameter int STEP_PIXELS  = 4,
    parameter int MOVE_DIV     = 1,
    parameter int XMIN         = 16,
    parameter int XMAX         = 623,
    parameter int YMIN         = 16,
    parameter int YMAX         = 463
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        turn_left,
    input  logic        turn_right,
    input  logic        edge_detected,
    output logic [18:0] bikeLocation_middle,
    output logic [2:0]  bike_orient,
    output logic        running,
    output logic        crashed,
    output logic        move_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_CRASHED = 2'd2
    } state_t;

    localparam logic [9:0]  START_X_L  = 10'(START_X);
    localparam logic [8:0]  START_Y_L  = 9'(START_Y);
    localparam logic [1:0]  START_O_L  = 2'(START_ORIENT);
    localparam logic [18:0] START_ADDR = 19'(START_Y * 640 + START_X);
    localparam logic [10:0] STEP_L     = 11'(STEP_PIXELS);
    localparam logic [10:0] XMIN_L     = 11'(XMIN);
    localparam logic [10:0] XMAX_L     = 11'(XMAX);
    localparam logic [10:0] YMIN_L     = 11'(YMIN);
    localparam logic [10:0] YMAX_L     = 11'(YMAX);
    localparam logic [7:0]  DIV_L      = 8'(MOVE_DIV);

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [1:0]  orient_q, orient_d;
    logic        pend_valid_q, pend_valid_d;
    logic        pend_left_q, pend_left_d;
    logic [7:0]  div_q, div_d;
    // Set when internal x/y/orient changed; presents them on the outputs one cycle later.
    logic        upd_q, upd_d;
    logic [18:0] addr_q, addr_d;
    logic [1:0]  orient_out_q, orient_out_d;
    logic        move_done_q, move_done_d;

    logic        move_tick;
    logic [1:0]  heading;
    logic [10:0] nx;
    logic [10:0] ny;
    logic        in_bounds;
    logic [18:0] y_ext;

    // Next-state, movement and output-stage logic.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        orient_d     = orient_q;
        pend_valid_d = pend_valid_q;
        pend_left_d  = pend_left_q;
        div_d        = div_q;
        upd_d        = 1'b0;
        addr_d       = addr_q;
        orient_out_d = orient_out_q;
        move_done_d  = 1'b0;
        move_tick    = 1'b0;
        heading      = orient_q;
        nx           = {1'b0, x_q};
        ny           = {2'b00, y_q};
        in_bounds    = 1'b1;
        y_ext        = {10'd0, y_q};

        // y*640 as two shifts keeps the multiplier out of the address path.
        if (upd_q) begin
            addr_d       = (y_ext << 9) + (y_ext << 7) + {9'd0, x_q};
            orient_out_d = orient_q;
            move_done_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    div_d   = 8'd0;
                end
            end
            S_RUN: begin
                if (edge_detected) begin
                    state_d = S_CRASHED;
                end else begin
                    if (frame_tick) begin
                        if (div_q + 8'd1 == DIV_L) begin
                            move_tick = 1'b1;
                            div_d     = 8'd0;
                        end else begin
                            div_d = div_q + 8'd1;
                        end
                    end
                    if (move_tick) begin
                        if (pend_valid_q) begin
                            heading = pend_left_q ? orient_q + 2'd1 : orient_q + 2'd3;
                        end
                        orient_d     = heading;
                        pend_valid_d = 1'b0;
                        case (heading)
                            2'd0:    ny = ny - STEP_L;
                            2'd1:    nx = nx - STEP_L;
                            2'd2:    ny = ny + STEP_L;
                            default: nx = nx + STEP_L;
                        endcase
                        // 11-bit compare catches subtraction underflow as a large value.
                        in_bounds = (nx >= XMIN_L) && (nx <= XMAX_L) &&
                                    (ny >= YMIN_L) && (ny <= YMAX_L);
                        if (in_bounds) begin
                            x_d   = nx[9:0];
                            y_d   = ny[8:0];
                            upd_d = 1'b1;
                        end else begin
`ifdef BIKE_WRAP_EN
                            x_d   = (nx < XMIN_L) ? XMAX_L[9:0] :
                                    (nx > XMAX_L) ? XMIN_L[9:0] : nx[9:0];
                            y_d   = (ny < YMIN_L) ? YMAX_L[8:0] :
                                    (ny > YMAX_L) ? YMIN_L[8:0] : ny[8:0];
                            upd_d = 1'b1;
`else
                            state_d = S_CRASHED;
`endif
                        end
                    end
                    // Requests arriving on a move tick wait for the next one.
                    if (turn_left ^ turn_right) begin
                        pend_valid_d = 1'b1;
                        pend_left_d  = turn_left;
                    end
                end
            end
            S_CRASHED: begin
                if (start) begin
                    x_d          = START_X_L;
                    y_d          = START_Y_L;
                    orient_d     = START_O_L;
                    pend_valid_d = 1'b0;
                    div_d        = 8'd0;
                    upd_d        = 1'b1;
                    state_d      = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= START_X_L;
            y_q          <= START_Y_L;
            orient_q     <= START_O_L;
            pend_valid_q <= 1'b0;
            pend_left_q  <= 1'b0;
            div_q        <= 8'd0;
            upd_q        <= 1'b0;
            addr_q       <= START_ADDR;
            orient_out_q <= START_O_L;
            move_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            orient_q     <= orient_d;
            pend_valid_q <= pend_valid_d;
            pend_left_q  <= pend_left_d;
            div_q        <= div_d;
            upd_q        <= upd_d;
            addr_q       <= addr_d;
            orient_out_q <= orient_out_d;
            move_done_q  <= move_done_d;
        end
    end

    assign bikeLocation_middle = addr_q;
    assign bike_orient         = {1'b0, orient_out_q};
    assign running             = (state_q == S_RUN);
    assign crashed             = (state_q == S_CRASHED);
    assign move_done           = move_done_q;

endmodule

// File: tb/tb_bike_controller.sv
// tb/tb_bike_controller.sv - self-checking bench for bike_controller against a behavioural model
module tb_bike_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic start = 1'b0;
    logic turn_left = 1'b0;
    logic turn_right = 1'b0;
    logic edge_detected = 1'b0;

    logic [18:0] addr_o [3];
    logic [2:0]  orient_o [3];
    logic        run_o [3];
    logic        crash_o [3];
    logic        md_o [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    // Instance 0: defaults; 1: starts near the right edge; 2: three frame ticks per move.
    bike_controller u_dut0 (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
        .turn_left(turn_left), .turn_right(turn_right), .edge_detected(edge_detected),
        .bikeLocation_middle(addr_o[0]), .bike_orient(orient_o[0]),
        .running(run_o[0]), .crashed(crash_o[0]), .move_done(md_o[0]));

    bike_controller #(.START_X(620)) u_dut1 (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
        .turn_left(turn_left), .turn_right(turn_right), .edge_detected(edge_detected),
        .bikeLocation_middle(addr_o[1]), .bike_orient(orient_o[1]),
        .running(run_o[1]), .crashed(crash_o[1]), .move_done(md_o[1]));

    bike_controller #(.MOVE_DIV(3)) u_dut2 (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
        .turn_left(turn_left), .turn_right(turn_right), .edge_detected(edge_detected),
        .bikeLocation_middle(addr_o[2]), .bike_orient(orient_o[2]),
        .running(run_o[2]), .crashed(crash_o[2]), .move_done(md_o[2]));

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: per-instance game state as plain integers.
    int sx [3] = '{320, 620, 320};
    int mdiv [3] = '{1, 1, 3};
    int dxs [4] = '{0, -1, 0, 1};
    int dys [4] = '{-1, 0, 1, 0};
    int m_st [3];      // 0 idle, 1 run, 2 crashed
    int m_x [3];
    int m_y [3];
    int m_o [3];
    int m_pend [3];    // 0 none, 1 left, 2 right
    int m_div [3];
    bit m_show [3];
    int e_addr [3];
    int e_or [3];
    bit e_md [3];
    bit model_ok = 1'b0;

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_st[k] = 0; m_x[k] = sx[k]; m_y[k] = 240; m_o[k] = 3;
                m_pend[k] = 0; m_div[k] = 0; m_show[k] = 1'b0;
                e_addr[k] = 240 * 640 + sx[k]; e_or[k] = 3; e_md[k] = 1'b0;
                model_ok = 1'b1;
            end else begin
                if (m_show[k]) begin
                    e_addr[k] = m_y[k] * 640 + m_x[k];
                    e_or[k]   = m_o[k];
                    e_md[k]   = 1'b1;
                end else begin
                    e_md[k] = 1'b0;
                end
                m_show[k] = 1'b0;
                if (m_st[k] == 0) begin
                    if (start) begin m_st[k] = 1; m_div[k] = 0; end
                end else if (m_st[k] == 1) begin
                    if (edge_detected) begin
                        m_st[k] = 2;
                    end else begin
                        if (frame_tick) begin
                            m_div[k]++;
                            if (m_div[k] == mdiv[k]) begin
                                int nx, ny;
                                m_div[k] = 0;
                                if (m_pend[k] == 1) m_o[k] = (m_o[k] + 1) % 4;
                                if (m_pend[k] == 2) m_o[k] = (m_o[k] + 3) % 4;
                                m_pend[k] = 0;
                                nx = m_x[k] + 4 * dxs[m_o[k]];
                                ny = m_y[k] + 4 * dys[m_o[k]];
                                if (nx >= 16 && nx <= 623 && ny >= 16 && ny <= 463) begin
                                    m_x[k] = nx; m_y[k] = ny; m_show[k] = 1'b1;
                                end else begin
`ifdef BIKE_WRAP_EN
                                    if (nx > 623) nx = 16;
                                    if (nx < 16)  nx = 623;
                                    if (ny > 463) ny = 16;
                                    if (ny < 16)  ny = 463;
                                    m_x[k] = nx; m_y[k] = ny; m_show[k] = 1'b1;
`else
                                    m_st[k] = 2;
`endif
                                end
                            end
                        end
                        if (turn_left && !turn_right) m_pend[k] = 1;
                        if (turn_right && !turn_left) m_pend[k] = 2;
                    end
                end else begin
                    if (start) begin
                        m_x[k] = sx[k]; m_y[k] = 240; m_o[k] = 3; m_pend[k] = 0;
                        m_div[k] = 0; m_st[k] = 1; m_show[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Compare every instance against the model shortly after each active edge.
    always @(posedge clock) begin
        #2;
        if (model_ok) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("addr[%0d]", k), int'(addr_o[k]), e_addr[k]);
                check($sformatf("orient[%0d]", k), int'(orient_o[k]), e_or[k]);
                check($sformatf("move_done[%0d]", k), int'(md_o[k]), int'(e_md[k]));
                check($sformatf("running[%0d]", k), int'(run_o[k]), (m_st[k] == 1) ? 1 : 0);
                check($sformatf("crashed[%0d]", k), int'(crash_o[k]), (m_st[k] == 2) ? 1 : 0);
            end
        end
    end

    task automatic pulse(input int which);
        case (which)
            0: frame_tick = 1'b1;
            1: start = 1'b1;
            2: turn_left = 1'b1;
            3: turn_right = 1'b1;
            4: begin turn_left = 1'b1; turn_right = 1'b1; end
            5: begin edge_detected = 1'b1; frame_tick = 1'b1; end
            default: reset = 1'b1;
        endcase
        @(negedge clock);
        frame_tick = 1'b0; start = 1'b0; turn_left = 1'b0; turn_right = 1'b0;
        edge_detected = 1'b0; reset = 1'b0;
    endtask

    task automatic tick_and_settle();
        pulse(0);
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset addr", int'(addr_o[0]), 153920);
        check("reset orient", int'(orient_o[0]), 3);
        check("reset flags", {run_o[0], crash_o[0], md_o[0]}, 0);

        pulse(1);
        tick_and_settle();
        check("first move addr", int'(addr_o[0]), 153924);
        check("first move orient", int'(orient_o[0]), 3);
        check("first move_done", int'(md_o[0]), 1);
`ifdef BIKE_WRAP_EN
        check("xmax wrap running", int'(run_o[1]), 1);
        check("xmax wrap addr", int'(addr_o[1]), 153616);
`else
        check("xmax crash", int'(crash_o[1]), 1);
        check("xmax crash addr", int'(addr_o[1]), 154220);
`endif
        @(negedge clock);
        check("move_done one cycle", int'(md_o[0]), 0);

        pulse(2);
        tick_and_settle();
        check("turn left orient", int'(orient_o[0]), 0);
        check("turn left addr", int'(addr_o[0]), 151364);

        pulse(3);
        tick_and_settle();
        check("turn right addr", int'(addr_o[0]), 151368);
        pulse(4);
        tick_and_settle();
        check("both turns orient", int'(orient_o[0]), 3);
        check("both turns addr", int'(addr_o[0]), 151372);

        pulse(5);
        check("edge crash", int'(crash_o[0]), 1);
        check("edge crash addr", int'(addr_o[0]), 151372);
        tick_and_settle();
        pulse(2);
        tick_and_settle();
        check("crashed frozen addr", int'(addr_o[0]), 151372);
        check("crashed frozen orient", int'(orient_o[0]), 3);
        pulse(1);
        check("restart running", int'(run_o[0]), 1);
        @(negedge clock);
        check("restart addr", int'(addr_o[0]), 153920);
        check("restart orient", int'(orient_o[0]), 3);
        check("restart move_done", int'(md_o[0]), 1);

        tick_and_settle();
        tick_and_settle();
        check("div3 hold addr", int'(addr_o[2]), 153920);
        tick_and_settle();
        check("div3 move addr", int'(addr_o[2]), 153924);
        check("div3 move_done", int'(md_o[2]), 1);
        check("div1 three moves", int'(addr_o[0]), 153932);

        pulse(6);
        check("mid reset addr", int'(addr_o[0]), 153920);
        check("mid reset flags", {run_o[0], crash_o[0], md_o[0]}, 0);

        pulse(1);
        pulse(2);
        for (int i = 0; i < 57; i++) tick_and_settle();
`ifdef BIKE_WRAP_EN
        check("ymin wrap running", int'(run_o[0]), 1);
        check("ymin wrap addr", int'(addr_o[0]), 296640);
`else
        check("ymin crash", int'(crash_o[0]), 1);
        check("ymin crash addr", int'(addr_o[0]), 10560);
`endif
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
